// File: rtl/req_priority_capture.sv
// Request capture front end: sticky pending bits served one at a time as a 3-bit code
// with valid/ready handshake. Define REQ_PRIORITY_CAPTURE_ROUND_ROBIN_EN for rotating priority.
module req_priority_capture #(
  parameter int DROP_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        req_in,
  input  logic              out_ready,
  output logic [2:0]        code,
  output logic              out_valid,
  output logic [7:0]        pending,
  output logic [DROP_W-1:0] drop_cnt
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state_q, state_d;
  logic [2:0]        code_q, code_d;
  logic [7:0]        pending_q, pending_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic [2:0] start_idx;
  logic [2:0] sel_idx;
  logic [2:0] cand;
  logic       found;
  logic       load;
  logic [7:0] clr_mask;
  logic       drop;

`ifdef REQ_PRIORITY_CAPTURE_ROUND_ROBIN_EN
  logic [2:0] last_idx_q, last_idx_d;

  // Search begins just below the last served index so every line gets a turn.
  assign start_idx  = last_idx_q - 3'd1;
  assign last_idx_d = load ? sel_idx : last_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_idx_q <= 3'd0;
    else        last_idx_q <= last_idx_d;
  end
`else
  assign start_idx = 3'd7;
`endif

  // Downward search with wrap; with start 7 this is plain highest-index-wins.
  always_comb begin
    sel_idx = 3'd0;
    found   = 1'b0;
    cand    = 3'd0;
    for (int i = 0; i < 8; i++) begin
      cand = start_idx - 3'(i);
      if (!found && pending_q[cand]) begin
        sel_idx = cand;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending_q != 8'd0) begin
          load    = 1'b1;
          code_d  = sel_idx;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          if (pending_q != 8'd0) begin
            load   = 1'b1;
            code_d = sel_idx;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Set wins over clear, so a re-asserted line stays pending after being served.
  assign clr_mask  = load ? (8'b1 << sel_idx) : 8'd0;
  assign pending_d = (pending_q & ~clr_mask) | req_in;
  assign drop      = |(req_in & pending_q & ~clr_mask);
  assign drop_d    = (drop && (drop_q != {DROP_W{1'b1}})) ? drop_q + DROP_W'(1) : drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      code_q    <= 3'd0;
      pending_q <= 8'd0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
    end
  end

  assign code      = code_q;
  assign out_valid = (state_q == HOLD);
  assign pending   = pending_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_req_priority_capture.sv
// Scoreboard bench for req_priority_capture: expected codes are queued when requests
// are driven and popped when the DUT presents a code.
module tb_req_priority_capture;

  localparam int DROP_W = 4;
  localparam int SAT    = (1 << DROP_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        req_in = 8'd0;
  logic              out_ready = 1'b0;
  logic [2:0]        code;
  logic              out_valid;
  logic [7:0]        pending;
  logic [DROP_W-1:0] drop_cnt;

  int checks = 0;
  int failures = 0;
  logic [2:0] exp_q[$];
  logic [2:0] exp_code;

  req_priority_capture #(.DROP_W(DROP_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .out_ready(out_ready),
    .code(code), .out_valid(out_valid), .pending(pending), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_in = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({code, out_valid, pending, drop_cnt} !== '0) begin
        failures++;
        $display("FAIL reset_hold: code=%0d valid=%0b pending=%02h drop=%0d, required all 0",
                 code, out_valid, pending, drop_cnt);
      end
    end
    rst_n = 1'b1; req_in = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({code, out_valid, pending, drop_cnt} !== '0) begin
        failures++;
        $display("FAIL reset_release: code=%0d valid=%0b pending=%02h drop=%0d, required all 0",
                 code, out_valid, pending, drop_cnt);
      end
    end
    $display("reset: done");
  endtask

  task automatic test_single();
    out_ready = 1'b1; req_in = 8'h10;
    exp_q.push_back(3'd4);
    tick();
    req_in = 8'h00;
    checks++;
    if (pending !== 8'h10 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_pending: pending=%02h valid=%0b, required 10/0", pending, out_valid);
    end
    tick();
    exp_code = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || code !== exp_code || pending !== 8'h00) begin
      failures++;
      $display("FAIL single_code: valid=%0b code=%0d pending=%02h, required 1/%0d/00",
               out_valid, code, pending, exp_code);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_end: valid=%0b, required 0", out_valid);
    end
    $display("single: code=4 served");
  endtask

  task automatic test_burst();
    out_ready = 1'b1; req_in = 8'hA5;
    exp_q.push_back(3'd7); exp_q.push_back(3'd5);
    exp_q.push_back(3'd2); exp_q.push_back(3'd0);
    tick();
    req_in = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_code = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || code !== exp_code) begin
        failures++;
        $display("FAIL burst_code%0d: valid=%0b code=%0d, required 1/%0d", i, out_valid, code, exp_code);
      end
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL burst_end: valid=%0b queue=%0d, required 0/0", out_valid, exp_q.size());
    end
    $display("burst: codes 7,5,2,0");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; req_in = 8'h01;
    exp_q.push_back(3'd0);
    tick();
    req_in = 8'h00;
    tick();
    req_in = 8'h80;
    exp_q.push_back(3'd7);
    tick();
    req_in = 8'h00;
    tick();
    checks++;
    if (out_valid !== 1'b1 || code !== 3'd0 || pending !== 8'h80) begin
      failures++;
      $display("FAIL bp_hold: valid=%0b code=%0d pending=%02h, required 1/0/80", out_valid, code, pending);
    end
    out_ready = 1'b1;
    exp_code = exp_q.pop_front();
    checks++;
    if (code !== exp_code) begin
      failures++;
      $display("FAIL bp_first: code=%0d, required %0d", code, exp_code);
    end
    tick();
    exp_code = exp_q.pop_front();
    checks++;
    if (out_valid !== 1'b1 || code !== exp_code) begin
      failures++;
      $display("FAIL bp_second: valid=%0b code=%0d, required 1/%0d", out_valid, code, exp_code);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_end: valid=%0b, required 0", out_valid);
    end
    $display("backpressure: codes 0,7");
  endtask

  task automatic test_drop();
    int exp_drop;
    rst_n = 1'b0; #1; rst_n = 1'b1;
    out_ready = 1'b0; req_in = 8'h03;
    exp_q.push_back(3'd1);
    tick();
    req_in = 8'h00;
    tick();
    exp_code = exp_q[0];
    checks++;
    if (out_valid !== 1'b1 || code !== exp_code || pending !== 8'h01 || drop_cnt !== '0) begin
      failures++;
      $display("FAIL drop_first: valid=%0b code=%0d pending=%02h drop=%0d, required 1/%0d/01/0",
               out_valid, code, pending, drop_cnt, exp_code);
    end
    tick(); tick();
    req_in = 8'h03;
    tick();
    req_in = 8'h00;
    checks++;
    if (drop_cnt !== DROP_W'(1) || pending !== 8'h03) begin
      failures++;
      $display("FAIL drop_one: drop=%0d pending=%02h, required 1/03", drop_cnt, pending);
    end
    req_in = 8'h01;
    for (int i = 0; i < 20; i++) begin
      tick();
      exp_drop = (2 + i > SAT) ? SAT : 2 + i;
      checks++;
      if (drop_cnt !== DROP_W'(exp_drop)) begin
        failures++;
        $display("FAIL drop_count%0d: drop=%0d, required %0d", i, drop_cnt, exp_drop);
      end
    end
    req_in = 8'h00;
    tick();
    checks++;
    if (drop_cnt !== DROP_W'(SAT) || out_valid !== 1'b1 || code !== exp_code) begin
      failures++;
      $display("FAIL drop_sat: drop=%0d valid=%0b code=%0d, required %0d/1/%0d",
               drop_cnt, out_valid, code, SAT, exp_code);
    end
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if ({code, out_valid, pending, drop_cnt} !== '0) begin
      failures++;
      $display("FAIL drop_async_rst: code=%0d valid=%0b pending=%02h drop=%0d, required all 0",
               code, out_valid, pending, drop_cnt);
    end
    tick();
    rst_n = 1'b1;
    $display("drop: saturated at %0d then reset", SAT);
  endtask

  task automatic test_priority();
    out_ready = 1'b1; req_in = 8'h81;
    for (int i = 0; i < 8; i++) begin
`ifdef REQ_PRIORITY_CAPTURE_ROUND_ROBIN_EN
      exp_q.push_back((i % 2 == 0) ? 3'd7 : 3'd0);
`else
      exp_q.push_back(3'd7);
`endif
    end
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_code = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || code !== exp_code) begin
        failures++;
        $display("FAIL priority%0d: valid=%0b code=%0d, required 1/%0d", i, out_valid, code, exp_code);
      end
    end
    req_in = 8'h00;
    $display("priority: 8 codes checked");
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_drop();
    test_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/req_priority_capture.md
Name: req_priority_capture

Overview:
- Sequential front end that sits directly upstream of the team's combinational 8-to-3 encoder.
- Captures eight request lines into sticky pending bits and serves them one at a time, highest priority first.
- Presents each served index as a 3-bit code with a valid/ready handshake.
- Counts requests lost because the same bit was still pending.

Parameters:
DROP_W, 4, width of the saturating drop counter (allowed range 1..16)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
req_in  input  8  request lines, sampled every cycle; bit i requests service for index i
out_ready  input  1  consumer accepts the code on a cycle where out_valid=1
code  output  3  index being served (registered)
out_valid  output  1  code is valid (registered)
pending  output  8  current sticky pending register
drop_cnt  output  DROP_W  saturating count of cycles in which at least one request was dropped

Behaviour:
- Reset: asynchronous on rst_n low. While rst_n=0 and after release: code=0, out_valid=0, pending=0, drop_cnt=0, FSM=IDLE. A reset mid-operation discards the in-flight code and all pending bits; nothing is replayed.
- Pending update, every edge: pending <= (pending & ~clr_mask) | req_in.
  - clr_mask is the one-hot bit loaded into code on that edge, else 0.
  - Set wins over clear: a bit loaded on the same edge that req_in re-asserts it stays pending.
- Drop detect: drop on an edge if any i has req_in[i]=1 and pending[i]=1 and clr_mask[i]=0. drop_cnt increments by 1 per such edge, regardless of how many bits dropped. It saturates at 2^DROP_W-1 and never wraps.
- Selection, fixed priority: the highest set index of the registered pending wins (bit 7 highest, bit 0 lowest).
- FSM, two states:
  - IDLE (out_valid=0): if pending!=0, load code with the selected index, set out_valid=1, clear that bit via clr_mask, go to HOLD. Otherwise stay in IDLE.
  - HOLD (out_valid=1): code and out_valid are held stable while out_ready=0. On an edge with out_ready=1:
    - if pending!=0, load the next selection, keep out_valid=1 and stay in HOLD (back-to-back, no bubble);
    - else set out_valid=0 and go to IDLE.
- Latency: a req_in bit sampled at edge k is in pending after edge k. It appears on code/out_valid after edge k+1 at the earliest, i.e. 2 cycles.
- Sustained throughput: one code per cycle while out_ready=1.
- The selection uses pending as it stood before the current edge; req_in on the current edge cannot be served on that same edge.
- A request line held high is re-served every time it wins, because set wins over clear. Under fixed priority it can starve lower bits.
- No pending bit is ever lost except through drop or reset.

Optional Feature:
REQ_PRIORITY_CAPTURE_ROUND_ROBIN_EN
- Defined: rotating priority.
  - A last_idx register resets to 0.
  - The search starts at (last_idx-1) mod 8 and proceeds downward with wrap, so the first search after reset starts at 7.
  - last_idx updates to the loaded code on every load.
  - All other behaviour is unchanged.
- Undefined: fixed priority as above; no last_idx register exists.

Test Plan:
- Reset: hold rst_n=0 with req_in=8'hFF -> code=0, out_valid=0, pending=0, drop_cnt=0 throughout. Release, then req_in=0 -> outputs stay 0.
- Single: req_in=8'h10 for one cycle, out_ready=1 -> pending=8'h10 after edge k; code=4, out_valid=1 after edge k+1 for exactly one cycle; then pending=0, out_valid=0.
- Burst: req_in=8'hA5 for one cycle, out_ready=1 -> code 7,5,2,0 on four consecutive cycles with out_valid continuously 1, then out_valid=0.
- Backpressure: out_ready=0, pulse 8'h01 -> code=0 held. Then pulse 8'h80 -> code stays 0 and pending=8'h80. Raise out_ready -> next cycle code=7, then out_valid=0.
- Drop and saturation: out_ready=0, pulse 8'h03 at cycles 1 and 5 -> bit1 is served and bit0 stays pending, so drop_cnt=1. Then re-pulse 8'h01 on 20 further cycles -> drop_cnt=15 (DROP_W=4) and stays 15. Assert rst_n=0 mid-HOLD -> all outputs 0 immediately.
- Priority mode: req_in=8'h81 held high, out_ready=1 -> without the macro code=7 every cycle; with REQ_PRIORITY_CAPTURE_ROUND_ROBIN_EN code alternates 7,0,7,0.
